instr_split_fifo: RTL and testbench

INSTR_SPLIT_FIFO -- requirements
Module: instr_split_fifo

---
 rtl/instr_split_if.sv | 25 ++
 rtl/instr_split_fifo.sv | 111 +++++++++++
 tb/tb_instr_split_fifo.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_split_if.sv
// Host/dispatcher-facing bus of instr_split_fifo: push port, two FIFO head ports, occupancy status.
interface instr_split_if #(parameter int ADDR_W = 4);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic              out_en0;
    logic              out_ack0;
    logic [31:0]       out_instr0;
    logic              out_en1;
    logic              out_ack1;
    logic [31:0]       out_instr1;
    logic [ADDR_W:0]   count0;
    logic [ADDR_W:0]   count1;
    logic [ADDR_W:0]   hwm;

    modport master (
        output flush, in_valid, in_instr, out_ack0, out_ack1,
        input  in_ready, out_en0, out_instr0, out_en1, out_instr1, count0, count1, hwm
    );
    modport slave (
        input  flush, in_valid, in_instr, out_ack0, out_ack1,
        output in_ready, out_en0, out_instr0, out_en1, out_instr1, count0, count1, hwm
    );
endinterface

// File: rtl/instr_split_fifo.sv
// Two-bank instruction FIFO: word k goes to bank k%2, each bank drains independently (FWFT).
// Optional peak-occupancy tracking on hwm is enabled by defining INSTR_SPLIT_STATS_EN.
module instr_split_bank #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [ADDR_W:0]   count
);
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    // Storage is deliberately left unreset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
endmodule

module instr_split_fifo #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic            clk,
    input  logic            rst,
    instr_split_if.slave    bus
);
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    logic                   wr_sel;
    logic                   accept;
    logic [1:0]             push;
    logic [1:0]             pop;
    logic [1:0]             ack;
    logic [1:0][31:0]       rdata;
    logic [1:0][ADDR_W:0]   count;

    // Readiness looks only at registered occupancy, so an ack frees space a cycle later.
    assign bus.in_ready = ~bus.flush & (count[wr_sel] != FULL);
    assign accept       = bus.in_valid & bus.in_ready;
    assign ack          = {bus.out_ack1, bus.out_ack0};

    always_ff @(posedge clk) begin
        if (rst || bus.flush) wr_sel <= 1'b0;
        else if (accept)      wr_sel <= ~wr_sel;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign push[b] = accept & (wr_sel == 1'(b));
        assign pop[b]  = (count[b] != '0) & ack[b];

        instr_split_bank #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_bank (
            .clk   (clk),
            .rst   (rst),
            .clr   (bus.flush),
            .push  (push[b]),
            .pop   (pop[b]),
            .wdata (bus.in_instr),
            .rdata (rdata[b]),
            .count (count[b])
        );
    end

    assign bus.out_en0    = (count[0] != '0);
    assign bus.out_en1    = (count[1] != '0);
    assign bus.out_instr0 = rdata[0];
    assign bus.out_instr1 = rdata[1];
    assign bus.count0     = count[0];
    assign bus.count1     = count[1];

`ifdef INSTR_SPLIT_STATS_EN
    logic [ADDR_W:0] hwm_q;
    logic [ADDR_W:0] peak;

    assign peak = (count[0] > count[1]) ? count[0] : count[1];

    // Flush leaves the peak intact; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst)               hwm_q <= '0;
        else if (peak > hwm_q) hwm_q <= peak;
    end

    assign bus.hwm = hwm_q;
`else
    assign bus.hwm = '0;
`endif
endmodule

// File: tb/tb_instr_split_fifo.sv
// Directed + randomized traffic bench for instr_split_fifo; queue-based reference model checked every cycle.
module tb_instr_split_fifo;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    instr_split_if #(.ADDR_W(ADDR_W)) bus ();

    instr_split_fifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: two plain queues, an alternating target and a running peak.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    bit          m_sel  = 1'b0;
    int          m_hwm  = 0;
    bit          m_live = 1'b0;

    always @(posedge clk) begin : model
        int  s0, s1;
        bit  acc;
        s0 = q0.size();
        s1 = q1.size();
        if (rst) begin
            q0.delete(); q1.delete();
            m_sel = 1'b0; m_hwm = 0; m_live = 1'b1;
        end else begin
`ifdef INSTR_SPLIT_STATS_EN
            if (s0 > m_hwm) m_hwm = s0;
            if (s1 > m_hwm) m_hwm = s1;
`endif
            if (bus.flush) begin
                q0.delete(); q1.delete();
                m_sel = 1'b0;
            end else begin
                acc = bus.in_valid && ((m_sel ? s1 : s0) < DEPTH);
                if (bus.out_ack0 && s0 > 0) void'(q0.pop_front());
                if (bus.out_ack1 && s1 > 0) void'(q1.pop_front());
                if (acc) begin
                    if (m_sel) q1.push_back(bus.in_instr);
                    else       q0.push_back(bus.in_instr);
                    m_sel = ~m_sel;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_live && !rst) begin
            chk("in_ready", 32'(bus.in_ready),
                32'(!bus.flush && ((m_sel ? q1.size() : q0.size()) < DEPTH)));
            chk("out_en0", 32'(bus.out_en0), 32'(q0.size() != 0));
            chk("out_en1", 32'(bus.out_en1), 32'(q1.size() != 0));
            chk("count0",  32'(bus.count0),  32'(q0.size()));
            chk("count1",  32'(bus.count1),  32'(q1.size()));
            chk("hwm",     32'(bus.hwm),     32'(m_hwm));
            if (q0.size() != 0) chk("out_instr0", bus.out_instr0, q0[0]);
            if (q1.size() != 0) chk("out_instr1", bus.out_instr1, q1[0]);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        bus.in_valid = 1'b1;
        bus.in_instr = w;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
    endtask

    task automatic fill(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) push_word(base + 32'(i));
    endtask

    initial begin
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.out_ack0 = 1'b0;
        bus.out_ack1 = 1'b0;
        step(2);
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_count0", 32'(bus.count0), 0);
        chk("rst_count1", 32'(bus.count1), 0);
        chk("rst_en0",    32'(bus.out_en0), 0);
        chk("rst_ready",  32'(bus.in_ready), 1);
        chk("rst_hwm",    32'(bus.hwm), 0);

        // Alternating split and joint pop
        push_word(32'hA);
        chk("latency_en0",   32'(bus.out_en0), 1);
        chk("latency_instr", bus.out_instr0, 32'hA);
        push_word(32'hB); push_word(32'hC); push_word(32'hD);
        chk("abcd_instr0", bus.out_instr0, 32'hA);
        chk("abcd_instr1", bus.out_instr1, 32'hB);
        chk("abcd_count0", 32'(bus.count0), 2);
        chk("abcd_count1", 32'(bus.count1), 2);
        bus.out_ack0 = 1'b1; bus.out_ack1 = 1'b1;
        step();
        chk("pop_instr0", bus.out_instr0, 32'hC);
        chk("pop_instr1", bus.out_instr1, 32'hD);
        step(3);   // acks held high while idle must not underflow
        chk("idle_count0", 32'(bus.count0), 0);
        bus.out_ack0 = 1'b0; bus.out_ack1 = 1'b0;

        // Fill both banks, then one pop reopens bank0
        fill(32, 32'h100);
        chk("full_ready",  32'(bus.in_ready), 0);
        chk("full_count0", 32'(bus.count0), 16);
        chk("full_count1", 32'(bus.count1), 16);
        bus.in_valid = 1'b1; bus.in_instr = 32'h133; bus.out_ack0 = 1'b1;
        #1;
        chk("ack_same_cycle_ready", 32'(bus.in_ready), 0);
        step();
        bus.out_ack0 = 1'b0;
        chk("ack_next_ready",  32'(bus.in_ready), 1);
        chk("ack_next_count0", 32'(bus.count0), 15);
        step();
        bus.in_valid = 1'b0;
        chk("w33_count0", 32'(bus.count0), 16);
        chk("w33_instr0", bus.out_instr0, 32'h102);

        // Bank1 full with wr_sel=1: push blocked, ack1 frees a slot
        bus.in_valid = 1'b1; bus.in_instr = 32'h134; bus.out_ack1 = 1'b1;
        step();
        bus.out_ack1 = 1'b0; bus.in_valid = 1'b0;
        chk("b1_pushpop_count1", 32'(bus.count1), 15);

        // Stall: bank0 full, bank1 at 15, wr_sel=0
        do_flush();
        fill(32, 32'h200);
        bus.out_ack1 = 1'b1;
        step();
        bus.out_ack1 = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = 32'h2FF;
        step(3);
        chk("stall_ready",  32'(bus.in_ready), 0);
        chk("stall_count1", 32'(bus.count1), 15);
        chk("stall_count0", 32'(bus.count0), 16);
        bus.in_valid = 1'b0;

        // Flush drops the presented word and resets the selector
        do_flush();
        fill(5, 32'h300);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_instr = 32'h3FF;
        #1;
        chk("flush_ready", 32'(bus.in_ready), 0);
        step();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_count0", 32'(bus.count0), 0);
        chk("flush_count1", 32'(bus.count1), 0);
        chk("flush_en1",    32'(bus.out_en1), 0);
        push_word(32'h400);
        chk("post_flush_count0", 32'(bus.count0), 1);
        chk("post_flush_count1", 32'(bus.count1), 0);

        // Peak tracking: 7/6 then drain and flush
        rst = 1'b1; step(); rst = 1'b0;
        fill(13, 32'h500);
        step();
        bus.out_ack0 = 1'b1; bus.out_ack1 = 1'b1;
        step(8);
        bus.out_ack0 = 1'b0; bus.out_ack1 = 1'b0;
        do_flush();
`ifdef INSTR_SPLIT_STATS_EN
        chk("hwm_peak", 32'(bus.hwm), 7);
`else
        chk("hwm_peak", 32'(bus.hwm), 0);
`endif
        fill(3, 32'h600);
        rst = 1'b1; step(); rst = 1'b0;
        chk("hwm_rst", 32'(bus.hwm), 0);
        push_word(32'h700);
        chk("rst_first_bank0", 32'(bus.count0), 1);
        chk("rst_first_instr", bus.out_instr0, 32'h700);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.in_valid = 1'($urandom_range(0, 3) != 0);
            bus.in_instr = $urandom;
            bus.out_ack0 = 1'($urandom_range(0, 2) == 0);
            bus.out_ack1 = 1'($urandom_range(0, 2) == 0);
            bus.flush    = 1'($urandom_range(0, 99) == 0);
            rst          = (i == 300);
            step();
        end
        rst = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;
        bus.out_ack0 = 1'b0; bus.out_ack1 = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
